// File: rtl/dfu_boot_helper_pkg.sv
// -----------------------------------------------------------------------------
// dfu_boot_helper_pkg
// Shared definitions for the DFU boot helper:
//   - default press-timer width
//   - BTN_MODE bit positions and small decode helpers
//   - DFU mode encoding and the image loaded by a button-initiated boot
//   - glitch-filter counter rails
// -----------------------------------------------------------------------------
package dfu_boot_helper_pkg;

  // Default timer width: 2^23 cycles is roughly 0.35 s at 24 MHz.
  localparam int unsigned DFU_TIMER_WIDTH_DEF = 24;

  // BTN_MODE bit positions. A mode of 2'b00 disables the button entirely.
  localparam logic BTN_ACTLOW_BIT = 1'b0;
  localparam logic BTN_PULLUP_BIT = 1'b1;
  localparam logic [1:0] BTN_MODE_DEF = 2'b11;

  // Image selected by a button-initiated warm boot.
  localparam logic [1:0] DFU_IMAGE = 2'b01;

  // Glitch-filter counter rails.
  localparam logic [3:0] FILT_CNT_MAX = 4'd15;
  localparam logic [3:0] FILT_CNT_MIN = 4'd0;

  // Button-release behaviour.
  typedef enum logic {
    DFU_LONG_PRESS = 1'b0,  // long release boots, short release requests soft reset
    DFU_ANY_PRESS  = 1'b1   // any release boots, soft reset never requested
  } dfu_mode_e;

  function automatic logic btn_active_low(input logic [1:0] mode);
    return mode[BTN_ACTLOW_BIT];
  endfunction

  function automatic logic btn_pullup_en(input logic [1:0] mode);
    return mode[BTN_PULLUP_BIT];
  endfunction

  function automatic logic btn_enabled(input logic [1:0] mode);
    return (mode != 2'b00);
  endfunction

endpackage

// File: rtl/btn_glitch_filter.sv
// -----------------------------------------------------------------------------
// btn_glitch_filter
// Two-flop synchroniser followed by a 4-bit saturating up/down counter with
// hysteresis. The output sets when the counter reaches 15 and clears when it
// reaches 0; in between it holds, so pulses shorter than 15 cycles never
// change it.
// Ports:
//   clk_24m  in   system clock
//   rst      in   async reset, active-high
//   btn_i    in   button level, 1 = pressed (asynchronous to clk_24m)
//   btn_o    out  debounced button level, 1 = pressed (registered)
// -----------------------------------------------------------------------------
module btn_glitch_filter
  import dfu_boot_helper_pkg::*;
(
  input  logic clk_24m,
  input  logic rst,
  input  logic btn_i,
  output logic btn_o
);

  logic [1:0] sync_q;
  logic [3:0] cnt_q;
  logic [3:0] cnt_d;
  logic       val_q;
  logic       val_d;

  // Synchroniser; sync_q[1] is the copy safe to use in logic.
  always_ff @(posedge clk_24m or posedge rst) begin
    if (rst) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], btn_i};
    end
  end

  // Counter and hysteresis next state. The decision looks at the next count
  // so btn_o moves on the same edge the counter hits a rail.
  always_comb begin
    cnt_d = cnt_q;
    val_d = val_q;
    if (sync_q[1]) begin
      if (cnt_q != FILT_CNT_MAX) begin
        cnt_d = cnt_q + 4'd1;
      end else begin
        cnt_d = cnt_q;
      end
    end else begin
      if (cnt_q != FILT_CNT_MIN) begin
        cnt_d = cnt_q - 4'd1;
      end else begin
        cnt_d = cnt_q;
      end
    end
    if (cnt_d == FILT_CNT_MAX) begin
      val_d = 1'b1;
    end else if (cnt_d == FILT_CNT_MIN) begin
      val_d = 1'b0;
    end else begin
      val_d = val_q;
    end
  end

  // Counter and output state registers.
  always_ff @(posedge clk_24m or posedge rst) begin
    if (rst) begin
      cnt_q <= FILT_CNT_MIN;
      val_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      val_q <= val_d;
    end
  end

  assign btn_o = val_q;

endmodule

// File: rtl/dfu_boot_helper.sv
// -----------------------------------------------------------------------------
// dfu_boot_helper
// Conditions the user button pad (IOB register, synchroniser, glitch filter,
// press-duration timer) and turns button releases and bus boot commands into
// a sticky iCE40 warm-boot request or a one-cycle soft-reset request.
// Ports:
//   clk_24m   in   system clock
//   rst       in   async reset, active-high
//   boot_now  in   bus-issued boot command (level)
//   boot_sel  in   [1:0] image for a bus-issued boot
//   btn_pad   in   raw button pad
//   btn_val   out  debounced button state, 1 = pressed
//   rst_req   out  one-cycle soft-reset request
//   boot_req  out  sticky warm-boot request (SB_WARMBOOT.BOOT)
//   boot_img  out  [1:0] selected image (SB_WARMBOOT.S1/S0)
// The iCE40 primitives are instantiated when ICE40_PRIMS is defined;
// otherwise behavioural equivalents are used.
// -----------------------------------------------------------------------------
module dfu_boot_helper
  import dfu_boot_helper_pkg::*;
#(
  parameter int unsigned TIMER_WIDTH = DFU_TIMER_WIDTH_DEF,
  parameter logic [1:0]  BTN_MODE    = BTN_MODE_DEF,
  parameter dfu_mode_e   DFU_MODE    = DFU_LONG_PRESS
) (
  input  logic       clk_24m,
  input  logic       rst,
  input  logic       boot_now,
  input  logic [1:0] boot_sel,
  input  logic       btn_pad,
  output logic       btn_val,
  output logic       rst_req,
  output logic       boot_req,
  output logic [1:0] boot_img
);

  localparam logic [TIMER_WIDTH-1:0] TIMER_ZERO = {TIMER_WIDTH{1'b0}};
  localparam logic [TIMER_WIDTH-1:0] TIMER_MAX  = {TIMER_WIDTH{1'b1}};
  localparam logic [TIMER_WIDTH-1:0] TIMER_ONE  = {{(TIMER_WIDTH-1){1'b0}}, 1'b1};

  logic                   pad_q;
  logic                   pressed_s;
  logic                   btn_val_s;
  logic                   btn_prev_q;
  logic [TIMER_WIDTH-1:0] timer_q;
  logic [TIMER_WIDTH-1:0] timer_d;
  logic                   release_s;
  logic                   long_s;
  logic                   btn_trig_s;
  logic                   short_rel_s;
  logic                   rst_req_q;
  logic                   rst_req_d;
  logic                   boot_req_q;
  logic                   boot_req_d;
  logic [1:0]             boot_img_q;
  logic [1:0]             boot_img_d;

`ifdef ICE40_PRIMS
  SB_IO #(
    .PIN_TYPE (6'b000000),
    .PULLUP   (btn_pullup_en(BTN_MODE))
  ) u_btn_io (
    .PACKAGE_PIN (btn_pad),
    .INPUT_CLK   (clk_24m),
    .D_IN_0      (pad_q)
  );
`else
  // IOB input register model; resets to the idle (not-pressed) pad level.
  always_ff @(posedge clk_24m or posedge rst) begin
    if (rst) begin
      pad_q <= btn_active_low(BTN_MODE);
    end else begin
      pad_q <= btn_pad;
    end
  end
`endif

  // Polarity fix-up: pressed_s is 1 while the button is held.
  always_comb begin
    pressed_s = 1'b0;
    if (!btn_enabled(BTN_MODE)) begin
      pressed_s = 1'b0;
    end else if (btn_active_low(BTN_MODE)) begin
      pressed_s = ~pad_q;
    end else begin
      pressed_s = pad_q;
    end
  end

  btn_glitch_filter u_filter (
    .clk_24m (clk_24m),
    .rst     (rst),
    .btn_i   (pressed_s),
    .btn_o   (btn_val_s)
  );

  // The release is seen the cycle after btn_val falls; timer_q still holds
  // the press duration then, since it only clears on the following edge.
  assign release_s   = btn_prev_q & ~btn_val_s;
  assign long_s      = timer_q[TIMER_WIDTH-1];
  assign btn_trig_s  = release_s & ((DFU_MODE == DFU_ANY_PRESS) | long_s);
  assign short_rel_s = release_s & (DFU_MODE == DFU_LONG_PRESS) & ~long_s;

  // Press timer and trigger resolution. Bus command beats a button trigger;
  // after boot_req is set everything else is ignored.
  always_comb begin
    timer_d    = timer_q;
    rst_req_d  = 1'b0;
    boot_req_d = boot_req_q;
    boot_img_d = boot_img_q;

    if (!btn_val_s) begin
      timer_d = TIMER_ZERO;
    end else if (timer_q != TIMER_MAX) begin
      timer_d = timer_q + TIMER_ONE;
    end else begin
      timer_d = timer_q;
    end

    if (boot_req_q) begin
      boot_req_d = 1'b1;
      boot_img_d = boot_img_q;
    end else if (boot_now) begin
      boot_req_d = 1'b1;
      boot_img_d = boot_sel;
    end else if (btn_trig_s) begin
      boot_req_d = 1'b1;
      boot_img_d = DFU_IMAGE;
    end else if (short_rel_s) begin
      rst_req_d = 1'b1;
    end else begin
      rst_req_d = 1'b0;
    end
  end

  // Timer, release edge detector and warm-boot/soft-reset registers.
  always_ff @(posedge clk_24m or posedge rst) begin
    if (rst) begin
      btn_prev_q <= 1'b0;
      timer_q    <= TIMER_ZERO;
      rst_req_q  <= 1'b0;
      boot_req_q <= 1'b0;
      boot_img_q <= 2'b00;
    end else begin
      btn_prev_q <= btn_val_s;
      timer_q    <= timer_d;
      rst_req_q  <= rst_req_d;
      boot_req_q <= boot_req_d;
      boot_img_q <= boot_img_d;
    end
  end

`ifdef ICE40_PRIMS
  SB_WARMBOOT u_warmboot (
    .BOOT (boot_req_q),
    .S1   (boot_img_q[1]),
    .S0   (boot_img_q[0])
  );
`endif

  assign btn_val  = btn_val_s;
  assign rst_req  = rst_req_q;
  assign boot_req = boot_req_q;
  assign boot_img = boot_img_q;

endmodule

// File: tb/tb_dfu_boot_helper.sv
// -----------------------------------------------------------------------------
// tb_dfu_boot_helper
// Directed bench for dfu_boot_helper with TIMER_WIDTH=8 (long = 128 cycles),
// BTN_MODE=3 (active-low pad) and DFU_MODE=0. Expected output vectors
// {btn_val, rst_req, boot_req, boot_img} are queued with the cycle at which
// they must appear and checked on the falling edge of that cycle.
// -----------------------------------------------------------------------------
module tb_dfu_boot_helper;
  import dfu_boot_helper_pkg::*;

  logic       clk_24m  = 1'b0;
  logic       rst      = 1'b1;
  logic       boot_now = 1'b0;
  logic [1:0] boot_sel = 2'b00;
  logic       btn_pad  = 1'b1;
  logic       btn_val;
  logic       rst_req;
  logic       boot_req;
  logic [1:0] boot_img;

  dfu_boot_helper #(
    .TIMER_WIDTH (8),
    .BTN_MODE    (2'b11),
    .DFU_MODE    (DFU_LONG_PRESS)
  ) dut (
    .clk_24m  (clk_24m),
    .rst      (rst),
    .boot_now (boot_now),
    .boot_sel (boot_sel),
    .btn_pad  (btn_pad),
    .btn_val  (btn_val),
    .rst_req  (rst_req),
    .boot_req (boot_req),
    .boot_img (boot_img)
  );

  always #5 clk_24m = ~clk_24m;

  // Rising-edge count; at a falling edge cyc equals the edges seen so far.
  int cyc = 0;
  always @(posedge clk_24m) cyc <= cyc + 1;

  // Cycles with rst_req high, counted independently of the scoreboard.
  int rst_pulses = 0;
  always @(negedge clk_24m) if (rst_req) rst_pulses <= rst_pulses + 1;

  typedef struct {
    string      tag;
    int         at;
    logic [4:0] exp;
  } exp_t;

  exp_t sbq[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_at(input string tag, input int at, input logic [4:0] v);
    exp_t e;
    e.tag = tag;
    e.at  = at;
    e.exp = v;
    sbq.push_back(e);
  endtask

  // Advance one cycle and retire every expectation due now.
  task automatic tick();
    @(negedge clk_24m);
    while (sbq.size() > 0 && sbq[0].at <= cyc) begin
      exp_t e;
      e = sbq.pop_front();
      check(e.tag, {3'b000, btn_val, rst_req, boot_req, boot_img}, {3'b000, e.exp});
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) tick();
  endtask

  initial begin
    int p;
    int r;

    // Reset held for 10 cycles, then released.
    expect_at("in_reset", 5, 5'b00000);
    rst = 1'b1;
    wait_cycles(10);
    rst = 1'b0;
    p = cyc;
    expect_at("reset_idle_1", p + 1, 5'b00000);
    expect_at("reset_idle_5", p + 5, 5'b00000);
    wait_cycles(6);

    // Glitch: 10-cycle press must not reach btn_val.
    p = cyc;
    btn_pad = 1'b0;
    expect_at("glitch_p12", p + 12, 5'b00000);
    expect_at("glitch_p17", p + 17, 5'b00000);
    expect_at("glitch_p25", p + 25, 5'b00000);
    wait_cycles(10);
    btn_pad = 1'b1;
    wait_cycles(30);
    check("glitch_no_rst_req", 8'(rst_pulses), 8'd0);

    // Short press: 50 cycles -> one rst_req pulse after release.
    p = cyc;
    btn_pad = 1'b0;
    expect_at("short_rise_m1", p + 17, 5'b00000);
    expect_at("short_rise",    p + 18, 5'b10000);
    expect_at("short_held",    p + 67, 5'b10000);
    expect_at("short_fall",    p + 68, 5'b00000);
    expect_at("short_rst_req", p + 69, 5'b01000);
    expect_at("short_rst_end", p + 70, 5'b00000);
    wait_cycles(50);
    btn_pad = 1'b1;
    wait_cycles(30);
    check("short_one_pulse", 8'(rst_pulses), 8'd1);

    // Long press: 300 cycles (timer saturates) -> boot image 01, sticky.
    p = cyc;
    btn_pad = 1'b0;
    expect_at("long_rise",    p + 18,   5'b10000);
    expect_at("long_sat",     p + 290,  5'b10000);
    expect_at("long_fall",    p + 318,  5'b00000);
    expect_at("long_boot",    p + 319,  5'b00101);
    expect_at("long_sticky",  p + 1319, 5'b00101);
    wait_cycles(300);
    btn_pad = 1'b1;
    wait_cycles(1030);
    check("long_no_rst_req", 8'(rst_pulses), 8'd1);

    // Bus boot with image 10, then a long press that must not change it.
    rst = 1'b1;
    expect_at("bus_pre_reset", cyc + 1, 5'b00000);
    wait_cycles(3);
    rst = 1'b0;
    wait_cycles(3);
    p = cyc;
    boot_sel = 2'b10;
    boot_now = 1'b1;
    expect_at("bus_boot", p + 1, 5'b00110);
    wait_cycles(1);
    boot_now = 1'b0;
    boot_sel = 2'b00;
    wait_cycles(4);
    p = cyc;
    btn_pad = 1'b0;
    expect_at("bus_btn_rise",  p + 18,  5'b10110);
    expect_at("bus_btn_fall",  p + 318, 5'b00110);
    expect_at("bus_img_kept",  p + 319, 5'b00110);
    expect_at("bus_img_later", p + 330, 5'b00110);
    wait_cycles(300);
    btn_pad = 1'b1;
    wait_cycles(35);
    check("bus_no_rst_req", 8'(rst_pulses), 8'd1);

    // Reset mid-press restarts the filter from not-pressed.
    rst = 1'b1;
    wait_cycles(3);
    rst = 1'b0;
    wait_cycles(3);
    p = cyc;
    btn_pad = 1'b0;
    expect_at("mid_rise", p + 18, 5'b10000);
    expect_at("mid_held", p + 30, 5'b10000);
    wait_cycles(30);
    rst = 1'b1;
    expect_at("mid_in_reset", cyc + 1, 5'b00000);
    wait_cycles(2);
    rst = 1'b0;
    r = cyc;
    expect_at("mid_restart_m1", r + 17, 5'b00000);
    expect_at("mid_restart",    r + 18, 5'b10000);
    expect_at("mid_fall",       r + 58, 5'b00000);
    expect_at("mid_rst_req",    r + 59, 5'b01000);
    expect_at("mid_rst_end",    r + 60, 5'b00000);
    wait_cycles(40);
    btn_pad = 1'b1;
    wait_cycles(25);
    check("mid_one_pulse", 8'(rst_pulses), 8'd2);

    // Bus trigger in the same cycle as a long-press release: bus wins.
    p = cyc;
    btn_pad = 1'b0;
    expect_at("sim_fall",  p + 318, 5'b00000);
    expect_at("sim_boot",  p + 319, 5'b00111);
    expect_at("sim_after", p + 324, 5'b00111);
    wait_cycles(300);
    btn_pad = 1'b1;
    wait_cycles(18);
    boot_sel = 2'b11;
    boot_now = 1'b1;
    wait_cycles(1);
    boot_now = 1'b0;
    boot_sel = 2'b00;
    wait_cycles(5);
    check("sim_no_rst_req", 8'(rst_pulses), 8'd2);

    // rst clears the sticky boot request.
    rst = 1'b1;
    expect_at("boot_cleared", cyc + 1, 5'b00000);
    wait_cycles(2);
    rst = 1'b0;
    wait_cycles(2);

    check("scoreboard_drained", 8'(sbq.size()), 8'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
